// File: rtl/pam_chk_pkg.sv
// Shared definitions for the PAM receive-side sequence checker:
// state encoding, default parameters and the byte-masked compare.
package pam_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        TRACK = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_CNT_WIDTH   = 32;
    localparam int unsigned DEF_LOSS_THRESH = 4;
    localparam int unsigned DEF_NUM_WORDS   = 1000;

    // Widest stream the masked compare supports; callers zero-extend and truncate.
    localparam int unsigned MAX_DW = 512;
    localparam int unsigned MAX_KW = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] masked_xor(
        input logic [MAX_DW-1:0] data,
        input logic [MAX_DW-1:0] expected,
        input logic [MAX_KW-1:0] keep
    );
        logic [MAX_DW-1:0] m;
        m = data ^ expected;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (!keep[i/8]) m[i] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/pam_chk_popcnt.sv
// Combinational population count of a data word; feeds the bit-error accumulator.
module pam_chk_popcnt #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]      din,
    output logic [$clog2(DATA_WIDTH):0] cnt
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            cnt = cnt + CNT_W'(din[i]);
        end
    end

endmodule

// File: rtl/pam_rx_checker.sv
// AXI-stream sink that hunts, locks onto and tracks an incrementing word
// sequence, counting words, frames, word/bit errors and lock losses.
module pam_rx_checker
    import pam_chk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int unsigned LOSS_THRESH = DEF_LOSS_THRESH,
    parameter int unsigned NUM_WORDS   = DEF_NUM_WORDS
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    s_axi_tvalid,
    output logic                    s_axi_tready,
    input  logic [DATA_WIDTH-1:0]   s_axi_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_tkeep,
    input  logic                    s_axi_tlast,
    input  logic [DATA_WIDTH-1:0]   cfg_seed,
    input  logic                    cfg_start,
    input  logic [7:0]              cfg_ready_pat,
    output logic                    locked,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    word_cnt,
    output logic [CNT_WIDTH-1:0]    err_word_cnt,
    output logic [CNT_WIDTH-1:0]    err_bit_cnt,
    output logic [CNT_WIDTH-1:0]    frame_cnt,
    output logic [CNT_WIDTH-1:0]    loss_cnt
);
    localparam int unsigned POP_W = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned CE_W  = $clog2(LOSS_THRESH + 1);

    chk_state_t              state, state_nxt;
    logic [7:0]              pat_reg;
    logic [DATA_WIDTH-1:0]   prev, expected, mx, xor_q;
    logic                    prev_valid;
    logic [CE_W-1:0]         consec_err, ce_nxt;
    logic [CNT_WIDTH-1:0]    word_nxt;
    logic [POP_W-1:0]        pop;
    logic                    hs, active, hunt_match, lock_hs, trk_hs, trk_done, trk_loss, done_q;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [POP_W-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(CNT_WIDTH + 1 - POP_W){1'b0}}, b};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    assign active       = (state == HUNT) || (state == TRACK);
    assign s_axi_tready = active & pat_reg[0] & ~cfg_start;
    assign hs           = s_axi_tvalid & s_axi_tready;
    assign locked       = (state == TRACK);
    assign done         = done_q;

    assign mx         = DATA_WIDTH'(masked_xor(MAX_DW'(s_axi_tdata), MAX_DW'(expected),
                                               MAX_KW'(s_axi_tkeep)));
    assign hunt_match = (s_axi_tdata == cfg_seed) ||
                        (prev_valid && (s_axi_tdata == prev + DATA_WIDTH'(1)));
    assign word_nxt   = sat_add(word_cnt, POP_W'(1));
    assign ce_nxt     = (|mx) ? consec_err + CE_W'(1) : '0;
    assign trk_done   = (word_nxt == CNT_WIDTH'(NUM_WORDS));
    assign trk_loss   = (ce_nxt == CE_W'(LOSS_THRESH));
    assign lock_hs    = (state == HUNT) && hs && hunt_match;
    assign trk_hs     = (state == TRACK) && hs;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cfg_start) begin
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT:    if (lock_hs) state_nxt = TRACK;
                TRACK:   if (trk_hs) begin
                             if (trk_done)      state_nxt = DONE;
                             else if (trk_loss) state_nxt = HUNT;
                         end
                default: state_nxt = state;
            endcase
        end
    end

    pam_chk_popcnt #(.DATA_WIDTH(DATA_WIDTH)) u_popcnt (
        .din (xor_q),
        .cnt (pop)
    );

    // Error path: masked XOR registered on the handshake, accumulated one edge later.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            xor_q        <= '0;
            err_word_cnt <= '0;
            err_bit_cnt  <= '0;
            done_q       <= 1'b0;
        end else if (cfg_start) begin
            xor_q        <= '0;
            err_word_cnt <= '0;
            err_bit_cnt  <= '0;
            done_q       <= 1'b0;
        end else begin
            xor_q  <= trk_hs ? mx : '0;
            done_q <= (state == DONE);
            if (|xor_q) begin
                err_word_cnt <= sat_add(err_word_cnt, POP_W'(1));
                err_bit_cnt  <= sat_add(err_bit_cnt, pop);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pat_reg    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            expected   <= '0;
            consec_err <= '0;
            word_cnt   <= '0;
            frame_cnt  <= '0;
            loss_cnt   <= '0;
        end else if (cfg_start) begin
            pat_reg    <= cfg_ready_pat;
            prev_valid <= 1'b0;
            consec_err <= '0;
            word_cnt   <= '0;
            frame_cnt  <= '0;
            loss_cnt   <= '0;
        end else begin
            if (active) pat_reg <= {pat_reg[0], pat_reg[7:1]};
            if (lock_hs) begin
                expected   <= s_axi_tdata + DATA_WIDTH'(1);
                word_cnt   <= CNT_WIDTH'(1);
                consec_err <= '0;
            end else if ((state == HUNT) && hs) begin
                prev       <= s_axi_tdata;
                prev_valid <= 1'b1;
            end
            if (trk_hs) begin
                word_cnt   <= word_nxt;
                expected   <= expected + DATA_WIDTH'(1);
                consec_err <= ce_nxt;
                if (s_axi_tlast) frame_cnt <= sat_add(frame_cnt, POP_W'(1));
                // Reaching the word budget wins over a loss on the same word.
                if (!trk_done && trk_loss) begin
                    loss_cnt   <= sat_add(loss_cnt, POP_W'(1));
                    prev_valid <= 1'b0;
                end
            end
        end
    end

endmodule
